// File: rtl/fll_ctrl_param.sv
// fll_ctrl_param: parametrised frequency-locked-loop controller.
// Counts clk_out cycles per reference window and steers the DCO word.
module fll_ctrl_param #(
    parameter int CTRL_W   = 5,
    parameter int MULT_W   = 6,
    parameter int WIN_W    = 5,
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int DEADBAND = 1
) (
    input  logic              clk_out,
    input  logic              rst,
    input  logic              ref_clk,
    input  logic [MULT_W-1:0] multi,
    input  logic [WIN_W-1:0]  avg_window,
    input  logic              freeze,
    output logic              lock_flag,
    output logic [CTRL_W-1:0] clk_con,
    output logic              meas_valid,
    output logic [CNT_W:0]    meas_err
);

    localparam int EW    = CNT_W + 1;
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    localparam logic [RUN_W-1:0]     RUN_MAX = RUN_W'(LOCK_CNT);
    localparam logic [CTRL_W-1:0]    MID     = CTRL_W'(1) << (CTRL_W - 1);
    localparam logic [CTRL_W-1:0]    STEP0   = (CTRL_W < 2) ? CTRL_W'(1) : (MID >> 1);
    localparam logic [CTRL_W-1:0]    CON_MAX = '1;
    localparam logic signed [CNT_W:0] DB     = EW'(DEADBAND);

    typedef enum logic {WAIT_START, COUNT} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t state, state_n;
    dir_t   last_dir, dir_now;

    logic ref_s1, ref_s2, ref_h, ref_edge;
    logic win_start, win_end, cap_v;

    logic [CNT_W-1:0] cyc_cnt, cyc_inc, actual_q, exp_cnt;
    logic [WIN_W-1:0] ref_cnt, n_eff, n_cur, n_done;

    logic [MULT_W+WIN_W-1:0] prod;
    logic signed [CNT_W:0]   err;

    logic in_band, too_slow, reverse;
    logic [CTRL_W-1:0] step, step_use, con_sub, con_add;
    logic [CTRL_W:0]   con_sum;
    logic [RUN_W-1:0]  run, run_nxt;

    assign ref_edge = ref_s2 & ~ref_h;
    assign cyc_inc  = (&cyc_cnt) ? cyc_cnt : cyc_cnt + CNT_W'(1);
    assign n_eff    = (avg_window == '0) ? WIN_W'(1) : avg_window;

    // Two-flop synchroniser plus history flop for rising-edge detection
    always_ff @(posedge clk_out) begin
        if (rst) begin
            ref_s1 <= 1'b0;
            ref_s2 <= 1'b0;
            ref_h  <= 1'b0;
        end else begin
            ref_s1 <= ref_clk;
            ref_s2 <= ref_s1;
            ref_h  <= ref_s2;
        end
    end

    // State register
    always_ff @(posedge clk_out) begin
        if (rst) state <= WAIT_START;
        else     state <= state_n;
    end

    // Next state and window start/end strobes
    always_comb begin
        state_n   = state;
        win_start = 1'b0;
        win_end   = 1'b0;
        unique case (state)
            WAIT_START: begin
                if (ref_edge) begin
                    state_n   = COUNT;
                    win_start = 1'b1;
                end
            end
            COUNT: begin
                if (ref_edge &&
                    ({1'b0, ref_cnt} + 1'b1 == {1'b0, n_cur}))
                    win_end = 1'b1;
            end
        endcase
    end

    // Cycle/reference counters; a window end restarts on the same edge
    always_ff @(posedge clk_out) begin
        if (rst) begin
            cyc_cnt  <= '0;
            ref_cnt  <= '0;
            n_cur    <= WIN_W'(1);
            n_done   <= WIN_W'(1);
            actual_q <= '0;
            cap_v    <= 1'b0;
        end else begin
            cap_v <= win_end;
            if (win_start) begin
                cyc_cnt <= '0;
                ref_cnt <= '0;
                n_cur   <= n_eff;
            end else if (state == COUNT) begin
                if (win_end) begin
                    actual_q <= cyc_inc;
                    n_done   <= n_cur;
                    cyc_cnt  <= '0;
                    ref_cnt  <= '0;
                    n_cur    <= n_eff;
                end else begin
                    cyc_cnt <= cyc_inc;
                    if (ref_edge) ref_cnt <= ref_cnt + WIN_W'(1);
                end
            end
        end
    end

    // Error, direction, halved step and saturated candidate words
    always_comb begin
        prod     = {{WIN_W{1'b0}}, multi} * {{MULT_W{1'b0}}, n_done};
        exp_cnt  = CNT_W'(prod);
        err      = {1'b0, actual_q} - {1'b0, exp_cnt};
        in_band  = (err >= -DB) && (err <= DB);
        too_slow = (err < -DB);
        dir_now  = too_slow ? DIR_UP : DIR_DN;
        reverse  = (last_dir != DIR_NONE) && (last_dir != dir_now);
        step_use = step;
        if (reverse)
            step_use = (step > CTRL_W'(1)) ? (step >> 1) : CTRL_W'(1);
        con_sub = (clk_con > step_use) ? clk_con - step_use : '0;
        con_sum = {1'b0, clk_con} + {1'b0, step_use};
        con_add = con_sum[CTRL_W] ? CON_MAX : con_sum[CTRL_W-1:0];
        run_nxt = '0;
        if (in_band)
            run_nxt = (run == RUN_MAX) ? run : run + RUN_W'(1);
    end

    // Compare stage: report error, update lock, steer word unless frozen
    always_ff @(posedge clk_out) begin
        if (rst) begin
            clk_con    <= MID;
            step       <= STEP0;
            last_dir   <= DIR_NONE;
            run        <= '0;
            lock_flag  <= 1'b0;
            meas_valid <= 1'b0;
            meas_err   <= '0;
        end else begin
            meas_valid <= cap_v;
            if (cap_v) begin
                meas_err  <= err;
                run       <= run_nxt;
                lock_flag <= (run_nxt == RUN_MAX);
                if (!in_band && !freeze) begin
                    step     <= step_use;
                    last_dir <= dir_now;
                    clk_con  <= too_slow ? con_sub : con_add;
                end
            end
        end
    end

endmodule

// File: tb/tb_fll_ctrl_param.sv
// tb_fll_ctrl_param: scenario bench for the FLL controller.
// Window results are predicted from generated reference edge times.
module tb_fll_ctrl_param;

    localparam int CTRL_W   = 5;
    localparam int MULT_W   = 6;
    localparam int WIN_W    = 5;
    localparam int CNT_W    = 16;
    localparam int LOCK_CNT = 4;
    localparam int DEADBAND = 1;

    logic              clk_out = 1'b0;
    logic              rst = 1'b1;
    logic              ref_clk = 1'b0;
    logic [MULT_W-1:0] multi = 6'd20;
    logic [WIN_W-1:0]  avg_window = 5'd4;
    logic              freeze = 1'b0;
    logic              lock_flag;
    logic [CTRL_W-1:0] clk_con;
    logic              meas_valid;
    logic [CNT_W:0]    meas_err;

    fll_ctrl_param #(
        .CTRL_W(CTRL_W), .MULT_W(MULT_W), .WIN_W(WIN_W),
        .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .DEADBAND(DEADBAND)
    ) dut (
        .clk_out(clk_out), .rst(rst), .ref_clk(ref_clk),
        .multi(multi), .avg_window(avg_window), .freeze(freeze),
        .lock_flag(lock_flag), .clk_con(clk_con),
        .meas_valid(meas_valid), .meas_err(meas_err)
    );

    always #5 clk_out = ~clk_out;

    typedef struct {
        int t;
        int err;
        int con;
        int lk;
    } rec_t;

    int   cyc = 0;
    rec_t got[$];
    rec_t exp_q[$];
    int   edges[$];
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk_out) cyc <= cyc + 1;

    // Log every reported window result with its cycle stamp
    always @(negedge clk_out) begin
        rec_t r;
        if (!rst && meas_valid) begin
            r.t   = cyc;
            r.err = int'($signed(meas_err));
            r.con = int'(clk_con);
            r.lk  = int'(lock_flag);
            got.push_back(r);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_out);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        ref_clk = 1'b0;
        tick(n);
        rst = 1'b0;
        got.delete();
        edges.delete();
    endtask

    // One rising edge per listed period, plus a closing edge
    task automatic drive(input int per[$], input int idle);
        foreach (per[i]) begin
            ref_clk = 1'b1;
            edges.push_back(cyc);
            for (int j = 0; j < per[i]; j++) begin
                if (j == per[i] / 2) ref_clk = 1'b0;
                tick(1);
            end
        end
        ref_clk = 1'b1;
        edges.push_back(cyc);
        tick(2);
        ref_clk = 1'b0;
        tick(idle);
    endtask

    // Reference model: windows of N edges, binary-search steering
    function automatic void build(input int mul, input int avg,
                                  input int frz);
        int n, con, stp, last, run, lk, a, e, d;
        n = (avg == 0) ? 1 : avg;
        con = 1 << (CTRL_W - 1);
        stp = 1 << (CTRL_W - 2);
        last = 0;
        run = 0;
        lk = 0;
        exp_q.delete();
        for (int w = 0; (w + 1) * n < edges.size(); w++) begin
            rec_t r;
            a = edges[(w + 1) * n] - edges[w * n];
            if (a > 65535) a = 65535;
            e = a - mul * n;
            if (e >= -DEADBAND && e <= DEADBAND) begin
                run = (run < LOCK_CNT) ? run + 1 : run;
                lk = (run == LOCK_CNT) ? 1 : 0;
            end else begin
                run = 0;
                lk = 0;
                if (frz == 0) begin
                    d = (e < 0) ? 1 : 2;
                    if (last != 0 && last != d)
                        stp = (stp > 1) ? stp / 2 : 1;
                    last = d;
                    if (d == 1) con = (con > stp) ? con - stp : 0;
                    else con = (con + stp > 31) ? 31 : con + stp;
                end
            end
            r.t = edges[(w + 1) * n] + 4;
            r.err = e;
            r.con = con;
            r.lk = lk;
            exp_q.push_back(r);
        end
    endfunction

    function automatic void fill(ref int q[$], input int p, input int k);
        for (int i = 0; i < k; i++) q.push_back(p);
    endfunction

    task automatic test_reset();
        do_reset(3);
        tick(4);
        vectors++;
        if (clk_con !== 5'd16) begin
            miscompares++;
            $display("FAIL reset clk_con got %0d want 16", clk_con);
        end
        vectors++;
        if (lock_flag !== 1'b0 || meas_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset flags got lock=%b valid=%b want 0 0",
                     lock_flag, meas_valid);
        end
        vectors++;
        if (meas_err !== '0) begin
            miscompares++;
            $display("FAIL reset meas_err got %0d want 0", meas_err);
        end
    endtask

    task automatic test_steady();
        int per[$];
        multi = 20;
        avg_window = 4;
        freeze = 0;
        do_reset(2);
        tick(3);
        fill(per, 20, 16);
        drive(per, 6);
        build(20, 4, 0);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL steady count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL steady win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
        vectors++;
        if (clk_con !== 5'd16 || lock_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL steady end got con=%0d lock=%b want 16 1",
                     clk_con, lock_flag);
        end
    endtask

    task automatic test_slow();
        int per[$];
        multi = 20;
        avg_window = 4;
        do_reset(2);
        tick(3);
        fill(per, 18, 16);
        drive(per, 6);
        build(20, 4, 0);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL slow count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL slow win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
        vectors++;
        if (clk_con !== 5'd0 || meas_err !== 17'h1fff8) begin
            miscompares++;
            $display("FAIL slow end got con=%0d err=%h want 0 1fff8",
                     clk_con, meas_err);
        end
    endtask

    task automatic test_alternate();
        int per[$];
        multi = 20;
        avg_window = 1;
        do_reset(2);
        tick(3);
        per = '{18, 22, 18, 22, 18};
        drive(per, 6);
        build(20, 1, 0);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL alternate count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL alternate win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
        vectors++;
        if (clk_con !== 5'd10) begin
            miscompares++;
            $display("FAIL alternate end clk_con got %0d want 10", clk_con);
        end
    endtask

    task automatic test_unlock();
        int per[$];
        multi = 20;
        avg_window = 4;
        do_reset(2);
        tick(3);
        fill(per, 20, 16);
        fill(per, 21, 4);
        fill(per, 20, 16);
        drive(per, 6);
        build(20, 4, 0);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL unlock count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL unlock win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
    endtask

    task automatic test_avg_zero();
        int per[$];
        multi = 20;
        avg_window = 0;
        do_reset(2);
        tick(3);
        fill(per, 20, 5);
        drive(per, 6);
        build(20, 0, 0);
        vectors++;
        if (got.size() !== 5) begin
            miscompares++;
            $display("FAIL avg_zero count got %0d want 5", got.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL avg_zero win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
    endtask

    task automatic test_freeze();
        int per[$];
        multi = 20;
        avg_window = 4;
        freeze = 1;
        do_reset(2);
        tick(3);
        fill(per, 18, 8);
        drive(per, 6);
        build(20, 4, 1);
        freeze = 0;
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL freeze count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL freeze win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
    endtask

    task automatic test_reset_mid();
        int per[$];
        multi = 20;
        avg_window = 4;
        do_reset(2);
        tick(3);
        fill(per, 18, 6);
        drive(per, 6);
        do_reset(1);
        vectors++;
        if (clk_con !== 5'd16 || lock_flag !== 1'b0 ||
            meas_valid !== 1'b0 || meas_err !== '0) begin
            miscompares++;
            $display("FAIL reset_mid outs got c=%0d l=%b v=%b e=%0d want 16 0 0 0",
                     clk_con, lock_flag, meas_valid, meas_err);
        end
        tick(3);
        per.delete();
        fill(per, 20, 8);
        drive(per, 6);
        build(20, 4, 0);
        vectors++;
        if (got.size() !== exp_q.size()) begin
            miscompares++;
            $display("FAIL reset_mid count got %0d want %0d",
                     got.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got.size()) begin
            vectors++;
            if (got[i] != exp_q[i]) begin
                miscompares++;
                $display("FAIL reset_mid win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                         i, got[i].t, got[i].err, got[i].con, got[i].lk,
                         exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            int per[$];
            int m, a, f;
            m = $urandom_range(26, 14);
            a = $urandom_range(3, 0);
            f = ($urandom_range(3, 0) == 0) ? 1 : 0;
            multi = MULT_W'(m);
            avg_window = WIN_W'(a);
            freeze = f[0];
            do_reset(2);
            tick(3);
            for (int i = 0; i < 12; i++)
                per.push_back($urandom_range(26, 14));
            drive(per, 6);
            build(m, a, f);
            freeze = 0;
            vectors++;
            if (got.size() !== exp_q.size()) begin
                miscompares++;
                $display("FAIL random%0d count got %0d want %0d",
                         k, got.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < got.size()) begin
                vectors++;
                if (got[i] != exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random%0d win %0d got t=%0d e=%0d c=%0d l=%0d want t=%0d e=%0d c=%0d l=%0d",
                             k, i, got[i].t, got[i].err, got[i].con, got[i].lk,
                             exp_q[i].t, exp_q[i].err, exp_q[i].con, exp_q[i].lk);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_slow();
        test_alternate();
        test_unlock();
        test_avg_zero();
        test_freeze();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
